// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed N-digit hex 7-segment driver. A load strobe captures a
//   new value, decimal points and blank mask into shadow registers. The
//   shadow contents move to the display registers only at a frame boundary,
//   when the scan wraps back to digit 0. Because of this the visible value
//   never tears mid-frame.
//
//   Ports
//     clk, rst_n          clock, async active-low reset
//     load                one-cycle capture strobe for value_in/dp_in/blank_in
//     value_in[4N-1:0]    hex nibbles, digit 0 in bits [3:0]
//     dp_in[N-1:0]        per-digit decimal point request (1 = lit)
//     blank_in[N-1:0]     per-digit force-dark, which includes the dp
//     lz_en               leading-zero suppression, sampled live
//     seg[6:0]            segments a..g (seg[6]=a), polarity per SEG_ACTIVE_LOW
//     dp                  decimal point, polarity per SEG_ACTIVE_LOW
//     an[N-1:0]           one-hot digit enable, polarity per AN_ACTIVE_LOW
//     frame_done          one-cycle pulse when digit 0 is (re)displayed

// Per-digit decode: hex -> logical segments (1 = lit) with blank and
// leading-zero handling.
module seg7_digit_dec (
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    input  logic       dp_req_i,
    input  logic       lz_sup_i,
    output logic [6:0] seg_o,
    output logic       dp_o
);
    logic [6:0] hex_seg;

    always_comb begin
        hex_seg = 7'b0000000;
        unique case (nib_i)
            4'h0: hex_seg = 7'b1111110;
            4'h1: hex_seg = 7'b0110000;
            4'h2: hex_seg = 7'b1101101;
            4'h3: hex_seg = 7'b1111001;
            4'h4: hex_seg = 7'b0110011;
            4'h5: hex_seg = 7'b1011011;
            4'h6: hex_seg = 7'b1011111;
            4'h7: hex_seg = 7'b1110000;
            4'h8: hex_seg = 7'b1111111;
            4'h9: hex_seg = 7'b1111011;
            4'hA: hex_seg = 7'b1110111;
            4'hB: hex_seg = 7'b0011111;
            4'hC: hex_seg = 7'b1001110;
            4'hD: hex_seg = 7'b0111101;
            4'hE: hex_seg = 7'b1001111;
            4'hF: hex_seg = 7'b1000111;
        endcase
    end

    // Blank beats everything. A suppressed leading zero still honours dp,
    // so a value such as "0.5" keeps its point.
    always_comb begin
        seg_o = hex_seg;
        dp_o  = dp_req_i;
        if (blank_i) begin
            seg_o = 7'b0000000;
            dp_o  = 1'b0;
        end else if (lz_sup_i) begin
            seg_o = 7'b0000000;
        end
    end
endmodule

module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0]                div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            pending_q, pending_d;
    logic [NUM_DIGITS-1:0][3:0]      sh_val_q, sh_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]           sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]           sh_blank_q, sh_blank_d, disp_blank_q, disp_blank_d;
    logic [6:0]                      seg_q, seg_d;
    logic                            dp_q, dp_d;
    logic [NUM_DIGITS-1:0]           an_q, an_d;
    logic                            frame_done_q, frame_done_d;

    logic                            tick, frame_start, upd;
    logic [IDX_W-1:0]                idx_nxt;
    logic [NUM_DIGITS-1:0][3:0]      in_val, src_val, eff_val;
    logic [NUM_DIGITS-1:0]           src_dp, src_blank, eff_dp, eff_blank;
    logic [NUM_DIGITS-1:0]           lz_sup, dig_dp, onehot;
    logic [NUM_DIGITS-1:0][6:0]      dig_seg;
    logic                            any_nz;

    assign in_val = value_in;

    always_comb begin
        tick        = (div_cnt_q == CNT_LAST);
        idx_nxt     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        frame_start = tick && (idx_nxt == '0);
        upd         = frame_start && (pending_q || load);

        // A load coinciding with a frame start bypasses the shadow.
        src_val   = load ? in_val   : sh_val_q;
        src_dp    = load ? dp_in    : sh_dp_q;
        src_blank = load ? blank_in : sh_blank_q;

        // These are the contents shown from this edge on. The outputs for
        // digit 0 must already reflect a frame-start update.
        eff_val   = upd ? src_val   : disp_val_q;
        eff_dp    = upd ? src_dp    : disp_dp_q;
        eff_blank = upd ? src_blank : disp_blank_q;

        div_cnt_d    = tick ? '0 : div_cnt_q + CNT_W'(1);
        idx_d        = tick ? idx_nxt : idx_q;
        pending_d    = frame_start ? 1'b0 : (pending_q | load);
        sh_val_d     = src_val;
        sh_dp_d      = src_dp;
        sh_blank_d   = src_blank;
        disp_val_d   = eff_val;
        disp_dp_d    = eff_dp;
        disp_blank_d = eff_blank;
    end

    // A digit is a leading zero when it and every digit above it are zero.
    // Digit 0 is exempt.
    always_comb begin
        any_nz = 1'b0;
        lz_sup = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            any_nz    = any_nz | (|eff_val[i]);
            lz_sup[i] = lz_en && (i != 0) && !any_nz;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        seg7_digit_dec u_dec (
            .nib_i    (eff_val[g]),
            .blank_i  (eff_blank[g]),
            .dp_req_i (eff_dp[g]),
            .lz_sup_i (lz_sup[g]),
            .seg_o    (dig_seg[g]),
            .dp_o     (dig_dp[g])
        );
    end

    always_comb begin
        onehot          = '0;
        onehot[idx_nxt] = 1'b1;
        seg_d        = tick ? (dig_seg[idx_nxt] ^ {7{SEG_INV}}) : seg_q;
        dp_d         = tick ? (dig_dp[idx_nxt] ^ SEG_INV)       : dp_q;
        an_d         = tick ? (onehot ^ {NUM_DIGITS{AN_INV}})   : an_q;
        frame_done_d = frame_start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            idx_q        <= IDX_LAST;
            pending_q    <= 1'b0;
            sh_val_q     <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            seg_q        <= {7{SEG_INV}};
            dp_q         <= SEG_INV;
            an_q         <= {NUM_DIGITS{AN_INV}};
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            sh_val_q     <= sh_val_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, SCAN_DIV=4, active-low pins.
// Outputs are sampled on the falling clock edge and inputs are driven there too.
module tb_seg7_scan_driver;
    localparam int ND = 4;

    // Active-low pin patterns, a..g
    localparam logic [6:0] S0   = 7'b0000001;
    localparam logic [6:0] S1   = 7'b1001111;
    localparam logic [6:0] S2   = 7'b0010010;
    localparam logic [6:0] S4   = 7'b1001100;
    localparam logic [6:0] S5   = 7'b0100100;
    localparam logic [6:0] S6   = 7'b0100000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0000100;
    localparam logic [6:0] SA   = 7'b0001000;
    localparam logic [6:0] SF   = 7'b0111000;
    localparam logic [6:0] DARK = 7'b1111111;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load = 1'b0;
    logic [4*ND-1:0] value_in = '0;
    logic [ND-1:0]   dp_in = '0;
    logic [ND-1:0]   blank_in = '0;
    logic            lz_en = 1'b0;
    logic [6:0]      seg;
    logic            dp;
    logic [ND-1:0]   an;
    logic            frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
        .dp_in(dp_in), .blank_in(blank_in), .lz_en(lz_en),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp, input logic e_fd);
        n_assert++;
        assert (an === e_an) else begin
            n_fail++; $error("FAIL %s an: observed %b expected %b", tag, an, e_an);
        end
        n_assert++;
        assert (seg === e_seg) else begin
            n_fail++; $error("FAIL %s seg: observed %b expected %b", tag, seg, e_seg);
        end
        n_assert++;
        assert (dp === e_dp) else begin
            n_fail++; $error("FAIL %s dp: observed %b expected %b", tag, dp, e_dp);
        end
        n_assert++;
        assert (frame_done === e_fd) else begin
            n_fail++; $error("FAIL %s frame_done: observed %b expected %b", tag, frame_done, e_fd);
        end
    endtask

    // Call on the falling edge right after a frame start. This returns
    // 12 cycles later, with digit 3 on display and 4 cycles left in the frame.
    task automatic check_frame(input string tag, input logic [3:0][6:0] e_seg,
                               input logic [3:0] e_dp);
        for (int k = 0; k < ND; k++) begin
            chk_out($sformatf("%s.d%0d", tag, k), 4'(~(4'b0001 << k)),
                    e_seg[k], e_dp[k], (k == 0));
            if (k < ND - 1) step(4);
        end
    endtask

    task automatic wait_frame_start(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) got = 1'b1;
        end
        n_assert++;
        assert (got === 1'b1) else begin
            n_fail++; $error("FAIL %s frame_start_wait: observed %b expected %b", tag, got, 1'b1);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value_in = v; dp_in = d; blank_in = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Call on the falling edge where rst_n has just been released.
    task automatic reset_seq(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("%s.idle%0d", tag, i), 4'b1111, DARK, 1'b1, 1'b0);
            step(1);
        end
        chk_out({tag, ".first"}, 4'b1110, S0, 1'b1, 1'b1);
        step(1);
        chk_out({tag, ".first+1"}, 4'b1110, S0, 1'b1, 1'b0);
        step(3);
        chk_out({tag, ".d1"}, 4'b1101, S0, 1'b1, 1'b0);
        step(4);
        chk_out({tag, ".d2"}, 4'b1011, S0, 1'b1, 1'b0);
        step(4);
        chk_out({tag, ".d3"}, 4'b0111, S0, 1'b1, 1'b0);
        step(4);
        chk_out({tag, ".wrap"}, 4'b1110, S0, 1'b1, 1'b1);
    endtask

    initial begin
        // Reset and the first scan
        step(3);
        chk_out("in_reset", 4'b1111, DARK, 1'b1, 1'b0);
        rst_n = 1'b1;
        reset_seq("rst1");

        // A load in mid-frame must not show until the next frame starts
        step(5);
        do_load(16'h12AF, 4'b0000, 4'b0000);
        step(2);
        chk_out("midload.d2", 4'b1011, S0, 1'b1, 1'b0);
        step(4);
        chk_out("midload.d3", 4'b0111, S0, 1'b1, 1'b0);
        wait_frame_start("12AF");
        check_frame("12AF", {S1, S2, SA, SF}, 4'b1111);

        // Leading-zero suppression
        lz_en = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        wait_frame_start("lz0050");
        check_frame("lz0050", {DARK, DARK, S5, S0}, 4'b1111);
        do_load(16'h0000, 4'b0000, 4'b0000);
        wait_frame_start("lz0000");
        check_frame("lz0000", {DARK, DARK, DARK, S0}, 4'b1111);

        // dp and blank: a suppressed digit keeps its dp, a blanked digit loses it
        do_load(16'h0050, 4'b0100, 4'b0010);
        wait_frame_start("dpblk_lz");
        check_frame("dpblk_lz", {DARK, DARK, DARK, S0}, 4'b1011);
        lz_en = 1'b0;
        do_load(16'h12AF, 4'b0100, 4'b0010);
        wait_frame_start("dpblk");
        check_frame("dpblk", {S1, S2, DARK, SF}, 4'b1011);

        // A load on the frame-start tick itself takes effect for that frame
        step(3);
        do_load(16'h8421, 4'b0000, 4'b0000);
        check_frame("bypass", {S8, S4, S2, S1}, 4'b1111);

        // With two loads in one frame, only the last one is shown
        do_load(16'h5555, 4'b0000, 4'b0000);
        do_load(16'h6009, 4'b0000, 4'b0000);
        wait_frame_start("twoload");
        check_frame("twoload", {S6, S0, S0, S9}, 4'b1111);

        // Reset asserted mid-frame acts at once, with no clock edge needed
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b1111, DARK, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_seq("rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
